// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one single-port memory between I-fetch and D-cache ports
module mem_arbiter #(
    parameter int AW      = 10,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ready,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          err,
    output logic          stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);
    localparam int            CW           = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST     = CW'(TIMEOUT - 1);
    localparam logic [DW-1:0] TIMEOUT_DATA = DW'(32'hDEADBEEF);
    localparam logic          OWN_I        = 1'b0;
    localparam logic          OWN_D        = 1'b1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_grant_q, last_grant_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_flag_q, err_flag_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          pick_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            owner_q      <= OWN_I;
            last_grant_q <= OWN_D;
            cnt_q        <= '0;
            err_flag_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            err_flag_q   <= err_flag_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        err_flag_d   = err_flag_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        // On a tie the port that did not win last time gets the grant
        pick_d       = d_req && (!i_req || (last_grant_q == OWN_I));
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    owner_d      = pick_d;
                    last_grant_d = pick_d;
                    mem_we_d     = pick_d && d_we;
                    mem_addr_d   = pick_d ? d_addr : i_addr;
                    if (pick_d) mem_wdata_d = d_wdata;
                    cnt_d        = '0;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CW'(1);
                if (mem_ready || (cnt_q == CNT_LAST)) begin
                    err_flag_d = !mem_ready;
                    if (owner_q == OWN_D) d_rdata_d = mem_ready ? mem_rdata : TIMEOUT_DATA;
                    else                  i_rdata_d = mem_ready ? mem_rdata : TIMEOUT_DATA;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem_req   = (state_q == BUSY);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_ready   = (state_q == RESP) && (owner_q == OWN_I);
    assign d_ready   = (state_q == RESP) && (owner_q == OWN_D);
    assign err       = (state_q == RESP) && err_flag_q;
    assign stall     = (i_req & ~i_ready) | (d_req & ~d_ready);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench: memory model plus per-port expected-response queues
module tb_mem_arbiter;
    localparam int          AW      = 10;
    localparam int          DW      = 32;
    localparam int          TIMEOUT = 16;
    localparam logic [31:0] DEAD    = 32'hDEADBEEF;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          i_req, d_req, d_we, mem_ready;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata, mem_rdata;
    logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic          i_ready, d_ready, err, stall, mem_req, mem_we;

    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready), .err(err), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        logic          chk_data;
    } exp_t;

    exp_t          q_i[$];
    exp_t          q_d[$];
    logic          order_q[$];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic [DW-1:0] bmem    [0:(1<<AW)-1];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            n_ready  = 0;
    int unsigned   resp_lat_max = 0;
    bit            stray_en = 1'b0;
    int            wait_cnt = -1;
    logic          snap_we;
    logic [AW-1:0] snap_addr;
    logic [DW-1:0] snap_wdata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Addresses with low nibble F model a memory bank that never answers
    function automatic logic is_dead(input logic [AW-1:0] a);
        return a[3:0] == 4'hF;
    endfunction

    task automatic i_txn(input logic [AW-1:0] addr, input int exp_lat);
        exp_t e;
        int   n;
        e.err = is_dead(addr);
        e.data = e.err ? DEAD : ref_mem[addr];
        e.chk_data = 1'b1;
        q_i.push_back(e);
        i_addr = addr;
        i_req  = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!i_ready && n < 60);
        if (!i_ready) begin
            n_checks++; n_fail++;
            $display("FAIL i_wait: no i_ready within %0d cycles for addr %0h", n, addr);
        end else if (exp_lat > 0) check("i_latency", n, exp_lat);
        @(posedge clk); #1;
        i_req = 1'b0;
    endtask

    task automatic d_txn(input logic [AW-1:0] addr, input logic we, input logic [DW-1:0] wd, input int exp_lat);
        exp_t e;
        int   n;
        e.err = is_dead(addr);
        if (we) begin
            if (!e.err) ref_mem[addr] = wd;
            e.data = DEAD;
            e.chk_data = e.err;
        end else begin
            e.data = e.err ? DEAD : ref_mem[addr];
            e.chk_data = 1'b1;
        end
        q_d.push_back(e);
        d_addr = addr; d_we = we; d_wdata = wd;
        d_req  = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!d_ready && n < 60);
        if (!d_ready) begin
            n_checks++; n_fail++;
            $display("FAIL d_wait: no d_ready within %0d cycles for addr %0h", n, addr);
        end else if (exp_lat > 0) check("d_latency", n, exp_lat);
        @(posedge clk); #1;
        d_req = 1'b0;
    endtask

    // Backing-memory responder
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            mem_ready = 1'b0;
            if (!reset_n || !mem_req) begin
                wait_cnt = -1;
                if (stray_en) begin mem_ready = 1'b1; mem_rdata = $urandom; end
            end else if (wait_cnt != -2) begin
                if (wait_cnt == -1) wait_cnt = int'($urandom_range(resp_lat_max, 0));
                if (wait_cnt == 0) begin
                    if (!is_dead(mem_addr)) begin
                        mem_ready  = 1'b1;
                        snap_we    = mem_we;
                        snap_addr  = mem_addr;
                        snap_wdata = mem_wdata;
                        if (mem_we) begin
                            bmem[mem_addr] = mem_wdata;
                            mem_rdata = $urandom;
                        end else mem_rdata = bmem[mem_addr];
                    end
                    wait_cnt = -2;
                end else wait_cnt--;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            check("stall", stall, (i_req & ~i_ready) | (d_req & ~d_ready));
            check("one_ready", i_ready & d_ready, 0);
            check("err_with_ready", err & ~(i_ready | d_ready), 0);
            if (i_ready) begin
                n_ready++;
                order_q.push_back(1'b0);
                if (q_i.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL i_spurious: i_ready with nothing outstanding, required none");
                end else begin
                    e = q_i.pop_front();
                    check("i_rdata", i_rdata, e.data);
                    check("i_err", err, e.err);
                end
            end
            if (d_ready) begin
                n_ready++;
                order_q.push_back(1'b1);
                if (q_d.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL d_spurious: d_ready with nothing outstanding, required none");
                end else begin
                    e = q_d.pop_front();
                    if (e.chk_data) check("d_rdata", d_rdata, e.data);
                    check("d_err", err, e.err);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ord;
        int         rc;
        i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        for (int k = 0; k < (1 << AW); k++) begin
            ref_mem[k] = $urandom;
            bmem[k] = ref_mem[k];
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_i_ready", i_ready, 0);
        check("rst_d_ready", d_ready, 0);
        check("rst_err", err, 0);
        check("rst_i_rdata", i_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        ref_mem[10'h010] = 32'h12345678; bmem[10'h010] = 32'h12345678;
        d_txn(10'h010, 1'b0, '0, 3);
        check("d_read_mem_we", snap_we, 0);
        check("d_read_mem_addr", snap_addr, 10'h010);

        d_txn(10'h020, 1'b1, 32'hCAFEF00D, 3);
        check("d_write_mem_we", snap_we, 1);
        check("d_write_mem_addr", snap_addr, 10'h020);
        check("d_write_mem_wdata", snap_wdata, 32'hCAFEF00D);
        d_txn(10'h020, 1'b0, '0, 3);

        order_q.delete();
        fork
            begin i_txn(10'h031, -1); i_txn(10'h042, -1); end
            begin d_txn(10'h253, 1'b0, '0, -1); d_txn(10'h264, 1'b1, $urandom, -1); end
        join
        for (int k = 0; k < 4; k++) ord[k] = (k < order_q.size()) ? order_q[k] : 1'bx;
        check("tie_order", ord, 4'b1010);

        i_txn(10'h0AF, TIMEOUT + 2);

        i_addr = 10'h13F; i_req = 1'b1;
        repeat (4) @(posedge clk);
        #3;
        check("busy_mem_req", mem_req, 1);
        reset_n = 1'b0;
        #1;
        check("async_rst_mem_req", mem_req, 0);
        check("async_rst_i_ready", i_ready, 0);
        check("async_rst_d_ready", d_ready, 0);
        check("async_rst_err", err, 0);
        i_req = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        order_q.delete();
        fork
            i_txn(10'h055, 3);
            d_txn(10'h2A6, 1'b0, '0, -1);
        join
        for (int k = 0; k < 2; k++) ord[k] = (k < order_q.size()) ? order_q[k] : 1'bx;
        check("post_reset_tie", ord[1:0], 2'b10);

        rc = n_ready;
        stray_en = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        stray_en = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("stray_ready_count", n_ready - rc, 0);

        fork
            i_txn(10'h077, 3);
            begin
                int k;
                k = 0;
                while (!i_ready && k < 50) begin @(negedge clk); k++; end
                d_txn(10'h288, 1'b0, '0, 3);
            end
        join

        resp_lat_max = 4;
        fork
            for (int k = 0; k < 40; k++) begin
                logic [AW-1:0] a;
                repeat ($urandom_range(3, 0)) begin @(posedge clk); #1; end
                a = {1'b0, 9'($urandom)};
                if ($urandom_range(7, 0) == 0) a[3:0] = 4'hF;
                i_txn(a, -1);
            end
            for (int k = 0; k < 40; k++) begin
                logic [AW-1:0] a;
                repeat ($urandom_range(3, 0)) begin @(posedge clk); #1; end
                a = {1'b1, 9'($urandom)};
                if ($urandom_range(7, 0) == 0) a[3:0] = 4'hF;
                d_txn(a, 1'($urandom), $urandom, -1);
            end
        join

        repeat (3) begin @(posedge clk); #1; end
        check("i_queue_empty", q_i.size(), 0);
        check("d_queue_empty", q_d.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
